// File: rtl/calc_pkg.sv
// Shared calculator definitions for the BCD conversion path.
// Contents: FSM state encoding, BCD digit width and limit, reverse
// double-dabble correction constants, and a digit validity helper.
package calc_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  // A shifted digit at or above CORR_THRESH had a 10 shifted into it as 8;
  // subtracting CORR_SUB restores it to 5 (half of ten).
  localparam int unsigned CORR_THRESH = 8;
  localparam int unsigned CORR_SUB    = 3;

  // True when a BCD digit holds a non-decimal code (A..F)
  function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/sub_three.sv
// Single BCD digit corrector for reverse double-dabble.
// Ports:
//   din    - shifted BCD digit
//   dout_c - corrected digit (combinational): din >= 8 ? din - 3 : din
module sub_three
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout_c
);

  // Subtract-3 correction, 4-bit, no borrow out
  always_comb begin
    dout_c = din;
    if (din >= BCD_DIGIT_W'(CORR_THRESH)) begin
      dout_c = din - BCD_DIGIT_W'(CORR_SUB);
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per
// cycle, with a start/busy/done handshake.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - conversion request, sampled only in IDLE
//   bcd_in     - packed BCD operand, digit 0 in bits [3:0]
//   busy       - high whenever the FSM is not in IDLE
//   done       - one-cycle completion pulse
//   bin_out    - converted value, low BIN_W bits (held until next done)
//   ovf        - converted value does not fit in BIN_W bits
//   err        - a digit of the accepted operand was above 9
module bcd_to_bin
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          ovf,
  output logic                          err
);

  localparam int unsigned TOT_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(TOT_W + 1);

  // Binary register bits above BIN_W; empty when the result always fits
  localparam logic [TOT_W-1:0] OVF_MASK =
    (BIN_W >= TOT_W) ? '0 : ({TOT_W{1'b1}} << BIN_W);

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   bcd_q, bcd_d;
  logic [TOT_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_d;
  logic               ovf_d, err_d, busy_d, done_d;

  logic [TOT_W-1:0]   bcd_sh, bcd_fix, bin_sh;
  logic [DIGITS-1:0]  digit_bad_v;
  logic               in_bad, last_shift, ovf_c;

  // Combined {bcd, bin} right shift; BCD LSB enters the binary MSB
  always_comb begin
    {bcd_sh, bin_sh} = {1'b0, bcd_q, bin_q[TOT_W-1:1]};
  end

  // Per-digit input check and post-shift correction
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign digit_bad_v[g] = digit_bad(bcd_in[g*BCD_DIGIT_W +: BCD_DIGIT_W]);

    sub_three u_fix (
      .din    (bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout_c (bcd_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign in_bad     = |digit_bad_v;
  assign last_shift = (cnt_q == CNT_W'(TOT_W - 1));
  assign ovf_c      = |(bin_sh & OVF_MASK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out;
    ovf_d     = ovf;
    err_d     = err;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            // Invalid operand: report immediately, no shifting
            err_d     = 1'b1;
            ovf_d     = 1'b0;
            bin_out_d = '0;
          end else begin
            bcd_d = bcd_in;
            bin_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
            ovf_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          // Final shift: publish the value produced on this same edge
          bin_out_d = BIN_W'(bin_sh);
          ovf_d     = ovf_c;
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      bin_out <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      bin_out <= bin_out_d;
      ovf     <= ovf_d;
      err     <= err_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard testbench for bcd_to_bin (DIGITS=3, BIN_W=8).
module tb_bcd_to_bin;

  typedef struct {
    logic [7:0] bin;
    logic       ovf;
    logic       err;
    longint     t;
    longint     lat;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  bin_out;
  logic        ovf;
  logic        err;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   done_stuck = 0;
  logic done_prev = 1'b0;

  res_t exp_q[$];
  res_t obs_q[$];

  bcd_to_bin #(.DIGITS(3), .BIN_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .ovf     (ovf),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: capture each done cycle with its time
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        res_t r;
        r.bin = bin_out;
        r.ovf = ovf;
        r.err = err;
        r.t   = longint'($time);
        r.lat = 0;
        obs_q.push_back(r);
        done_cnt++;
        if (done_prev) done_stuck++;
      end
      done_prev = done;
    end
  end

  // Reference: decimal value of the digits; latency from accept edge to done sample
  function automatic res_t model(input logic [11:0] b);
    res_t r;
    int   v;
    r.t = 0;
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9 || b[11:8] > 4'd9) begin
      r.bin = 8'h00;
      r.ovf = 1'b0;
      r.err = 1'b1;
      r.lat = 5;
    end else begin
      v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
      r.bin = 8'(v);
      r.ovf = (v >= 256);
      r.err = 1'b0;
      r.lat = 125;
    end
    return r;
  endfunction

  // One-cycle start pulse; expectation recorded at the accepting edge
  task automatic start_one(input logic [11:0] v);
    res_t e;
    @(posedge clk);
    #1;
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    e = model(v);
    e.t = longint'($time);
    exp_q.push_back(e);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 5;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got %b want 0", done); end
    if (bin_out !== 8'h0) begin bad++; $display("FAIL reset_bin got %h want 00", bin_out); end
    if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_basic;
    logic [11:0] vals [2];
    res_t e, o;
    bit   ok;
    vals[0] = 12'h255;
    vals[1] = 12'h999;
    for (int k = 0; k < 2; k++) begin
      start_one(vals[k]);
      @(negedge clk);
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got %b want 1", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got %b want 0", done); end
      wait_obs(1, 40, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL basic_timeout bcd=%h no done", vals[k]);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        total += 4;
        if (o.bin !== e.bin) begin bad++; $display("FAIL basic_bin bcd=%h got %h want %h", vals[k], o.bin, e.bin); end
        if (o.ovf !== e.ovf) begin bad++; $display("FAIL basic_ovf bcd=%h got %b want %b", vals[k], o.ovf, e.ovf); end
        if (o.err !== e.err) begin bad++; $display("FAIL basic_err bcd=%h got %b want %b", vals[k], o.err, e.err); end
        if (o.t - e.t != e.lat) begin bad++; $display("FAIL basic_latency bcd=%h got %0d want %0d", vals[k], o.t - e.t, e.lat); end
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got %b want 0", busy); end
    end
  endtask

  task automatic test_back_to_back;
    res_t e, o;
    bit   ok;
    int   dc0;
    int   ds0;
    dc0 = done_cnt;
    ds0 = done_stuck;
    @(posedge clk);
    #1;
    start  = 1'b1;
    bcd_in = 12'h000;
    @(posedge clk);
    e = model(12'h000);
    e.t = longint'($time);
    exp_q.push_back(e);
    #1;
    bcd_in = 12'h128;
    repeat (14) @(posedge clk);
    e = model(12'h128);
    e.t = longint'($time);
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    wait_obs(2, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout got %0d dones want 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if (o.bin !== e.bin) begin bad++; $display("FAIL b2b_bin got %h want %h", o.bin, e.bin); end
      if (o.ovf !== e.ovf) begin bad++; $display("FAIL b2b_ovf got %b want %b", o.ovf, e.ovf); end
      if (o.err !== e.err) begin bad++; $display("FAIL b2b_err got %b want %b", o.err, e.err); end
      if (o.t - e.t != e.lat) begin bad++; $display("FAIL b2b_latency got %0d want %0d", o.t - e.t, e.lat); end
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    total += 2;
    if (done_cnt - dc0 != 2)    begin bad++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - dc0); end
    if (done_stuck - ds0 != 0)  begin bad++; $display("FAIL b2b_done_width got %0d long pulses want 0", done_stuck - ds0); end
  endtask

  task automatic test_invalid;
    res_t e, o;
    bit   ok;
    start_one(12'h1A3);
    wait_obs(1, 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL inv_timeout no done");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 4;
      if (o.bin !== e.bin) begin bad++; $display("FAIL inv_bin got %h want %h", o.bin, e.bin); end
      if (o.ovf !== e.ovf) begin bad++; $display("FAIL inv_ovf got %b want %b", o.ovf, e.ovf); end
      if (o.err !== e.err) begin bad++; $display("FAIL inv_err got %b want %b", o.err, e.err); end
      if (o.t - e.t != e.lat) begin bad++; $display("FAIL inv_latency got %0d want %0d", o.t - e.t, e.lat); end
    end
    repeat (4) @(negedge clk);
    total += 2;
    if (err !== 1'b1)  begin bad++; $display("FAIL inv_err_hold got %b want 1", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL inv_busy_idle got %b want 0", busy); end
    start_one(12'h042);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL inv_err_clear got %b want 0", err); end
    wait_obs(1, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL inv_next_timeout no done");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 3;
      if (o.bin !== e.bin) begin bad++; $display("FAIL inv_next_bin got %h want %h", o.bin, e.bin); end
      if (o.err !== e.err) begin bad++; $display("FAIL inv_next_err got %b want %b", o.err, e.err); end
      if (o.t - e.t != e.lat) begin bad++; $display("FAIL inv_next_latency got %0d want %0d", o.t - e.t, e.lat); end
    end
  endtask

  task automatic test_start_ignored;
    res_t e, o;
    bit   ok;
    int   dc0;
    dc0 = done_cnt;
    start_one(12'h100);
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    bcd_in = 12'h077;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 12'h000;
    wait_obs(1, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ign_timeout no done");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 3;
      if (o.bin !== e.bin) begin bad++; $display("FAIL ign_bin got %h want %h", o.bin, e.bin); end
      if (o.ovf !== e.ovf) begin bad++; $display("FAIL ign_ovf got %b want %b", o.ovf, e.ovf); end
      if (o.t - e.t != e.lat) begin bad++; $display("FAIL ign_latency got %0d want %0d", o.t - e.t, e.lat); end
    end
    repeat (20) @(negedge clk);
    total += 2;
    if (obs_q.size() != 0)   begin bad++; $display("FAIL ign_extra_done got %0d want 0", obs_q.size()); end
    if (done_cnt - dc0 != 1) begin bad++; $display("FAIL ign_done_count got %0d want 1", done_cnt - dc0); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    res_t e, o;
    bit   ok;
    start_one(12'h321);
    void'(exp_q.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL rmid_done got %b want 0", done); end
    if (bin_out !== 8'h0) begin bad++; $display("FAIL rmid_bin got %h want 00", bin_out); end
    if (ovf !== 1'b0)     begin bad++; $display("FAIL rmid_ovf got %b want 0", ovf); end
    if (err !== 1'b0)     begin bad++; $display("FAIL rmid_err got %b want 0", err); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_abandoned_done got %0d want 0", obs_q.size()); end
    obs_q.delete();
    start_one(12'h200);
    wait_obs(1, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rmid_fresh_timeout no done");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total += 3;
      if (o.bin !== e.bin) begin bad++; $display("FAIL rmid_fresh_bin got %h want %h", o.bin, e.bin); end
      if (o.ovf !== e.ovf) begin bad++; $display("FAIL rmid_fresh_ovf got %b want %b", o.ovf, e.ovf); end
      if (o.t - e.t != e.lat) begin bad++; $display("FAIL rmid_fresh_latency got %0d want %0d", o.t - e.t, e.lat); end
    end
  endtask

  task automatic test_random;
    res_t        e, o;
    bit          ok;
    logic [11:0] v;
    for (int k = 0; k < 8; k++) begin
      v[3:0]  = 4'($urandom_range(0, 11));
      v[7:4]  = 4'($urandom_range(0, 11));
      v[11:8] = 4'($urandom_range(0, 11));
      start_one(v);
      wait_obs(1, 40, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rand_timeout bcd=%h no done", v);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        total += 4;
        if (o.bin !== e.bin) begin bad++; $display("FAIL rand_bin bcd=%h got %h want %h", v, o.bin, e.bin); end
        if (o.ovf !== e.ovf) begin bad++; $display("FAIL rand_ovf bcd=%h got %b want %b", v, o.ovf, e.ovf); end
        if (o.err !== e.err) begin bad++; $display("FAIL rand_err bcd=%h got %b want %b", v, o.err, e.err); end
        if (o.t - e.t != e.lat) begin bad++; $display("FAIL rand_latency bcd=%h got %0d want %0d", v, o.t - e.t, e.lat); end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
